rle_video_prefetch: RTL and testbench

Parametrised run-length video decoder with a prefetch FIFO and N-fold frame repetition. It sits between the SPI/QSPI stream reader and the VGA colour output. Words from the reader are buffered so that a pixel-rate run change never stalls. Each stored frame is shown REPEAT times by saving and reloading the reader address, and the stream restarts on an end marker.

---
 rtl/rle_pkg.sv | 22 ++
 rtl/rle_prefetch_fifo.sv | 52 +++++
 rtl/rle_video_prefetch.sv | 138 +++++++++++++
 tb/tb_rle_video_prefetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared state type and word-field helpers for the RLE video decoder
package rle_pkg;

  typedef enum logic {
    RESTART = 1'b0,
    RUN     = 1'b1
  } state_e;

  // Helpers work on a 32-bit view of a word; callers narrow the result to field width.
  function automatic logic [31:0] end_marker(input int run_w);
    return (32'd1 << run_w) - 32'd1;
  endfunction

  function automatic logic [31:0] run_field(input logic [31:0] word, input int colour_w);
    return word >> colour_w;
  endfunction

  function automatic logic [31:0] colour_field(input logic [31:0] word, input int colour_w);
    return word & ((32'd1 << colour_w) - 32'd1);
  endfunction

endpackage

// File: rtl/rle_prefetch_fifo.sv
// rtl/rle_prefetch_fifo.sv - first-word-fall-through prefetch FIFO with flush
module rle_prefetch_fifo #(
  parameter int  DEPTH = 4,
  parameter int  DW    = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rle_video_prefetch.sv
// rtl/rle_video_prefetch.sv - run-length video decoder with prefetch FIFO and frame repetition
module rle_video_prefetch
  import rle_pkg::*;
#(
  parameter int  RUN_W      = 10,
  parameter int  COLOUR_W   = 6,
  parameter int  FIFO_DEPTH = 4,
  parameter int  REPEAT     = 2,
  localparam int DW         = RUN_W + COLOUR_W,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                read_next,
  output logic                stop_data,
  input  logic                data_ready,
  input  logic [DW-1:0]       data,
  input  logic                next_frame,
  input  logic                next_pixel,
  output logic [COLOUR_W-1:0] colour,
  output logic                save_addr,
  output logic                load_addr,
  output logic                clear_addr,
  output logic [CW-1:0]       fifo_count,
  output logic                underrun
);

  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  state_e              state_q;
  logic [RUN_W-1:0]    run_q;
  logic [RW-1:0]       rep_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                clear_q, underrun_q;

  logic                full, empty, push, pop, flush, last_rep, starve, dec;
  logic [DW-1:0]       head;
  logic [31:0]         head_ext;
  logic [RUN_W-1:0]    head_run;
  logic [COLOUR_W-1:0] head_colour;
  logic                head_end;

  rle_prefetch_fifo #(.DEPTH(FIFO_DEPTH), .DW(DW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (data),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign head_ext    = 32'(head);
  assign head_run    = RUN_W'(run_field(head_ext, COLOUR_W));
  assign head_colour = COLOUR_W'(colour_field(head_ext, COLOUR_W));
  assign head_end    = (head_run == RUN_W'(end_marker(RUN_W)));

  assign last_rep  = (rep_q == RW'(REPEAT - 1));
  assign stop_data = (state_q == RESTART) || (next_frame && !last_rep);
  assign read_next = !stop_data && !full;
  assign push      = read_next && data_ready;

  assign colour     = colour_q;
  assign clear_addr = clear_q;
  assign underrun   = underrun_q;

  // Frame strobes take priority; a pixel strobe in the same cycle is dropped.
  always_comb begin
    pop       = 1'b0;
    flush     = 1'b0;
    save_addr = 1'b0;
    load_addr = 1'b0;
    starve    = 1'b0;
    dec       = 1'b0;
    if (state_q == RESTART) begin
      flush     = 1'b1;
      save_addr = next_frame;
    end else if (next_frame) begin
      save_addr = last_rep;
      load_addr = !last_rep;
      flush     = !last_rep;
    end else if (run_q == '0 && !empty) begin
      pop = 1'b1;
    end else if (next_pixel && run_q == RUN_W'(1)) begin
      pop    = !empty;
      starve = empty;
    end else if (next_pixel && run_q == '0) begin
      starve = 1'b1;
    end else if (next_pixel) begin
      dec = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RESTART;
      run_q      <= '0;
      rep_q      <= '0;
      colour_q   <= '0;
      clear_q    <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= starve;
      if (state_q == RESTART) begin
        colour_q <= '0;
        rep_q    <= '0;
        clear_q  <= 1'b1;
        if (next_frame) begin
          state_q <= RUN;
          clear_q <= 1'b0;
          run_q   <= '0;
        end
      end else begin
        if (save_addr) rep_q <= '0;
        if (load_addr) begin
          rep_q <= rep_q + RW'(1);
          run_q <= '0;
        end
        if (starve) run_q <= '0;
        if (dec)    run_q <= run_q - RUN_W'(1);
        // A zero run only loads a colour; the next word is popped on the following cycle.
        if (pop) begin
          if (head_end) begin
            state_q <= RESTART;
            clear_q <= 1'b1;
          end else begin
            colour_q <= head_colour;
            run_q    <= head_run;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rle_video_prefetch.sv
// tb/tb_rle_video_prefetch.sv - scoreboard bench for rle_video_prefetch
module tb_rle_video_prefetch;

  localparam int RUN_W    = 10;
  localparam int COLOUR_W = 6;
  localparam int DW       = 16;
  localparam int CW       = 3;

  localparam int EV_CLEAR = 0;
  localparam int EV_COL   = 1;
  localparam int EV_SAVE  = 2;
  localparam int EV_LOAD  = 3;
  localparam int EV_UNDR  = 4;
  localparam int EV_PIX   = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                read_next, stop_data;
  logic                data_ready = 1'b0;
  logic [DW-1:0]       data = '0;
  logic                next_frame = 1'b0;
  logic                next_pixel = 1'b0;
  logic [COLOUR_W-1:0] colour;
  logic                save_addr, load_addr, clear_addr;
  logic [CW-1:0]       fifo_count;
  logic                underrun;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  ev_t           exp_q[$];
  logic [DW-1:0] feed_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          mon_en   = 1'b0;
  logic          feed_en  = 1'b0;
  logic          xfer     = 1'b0;
  logic          prev_clear;
  logic [COLOUR_W-1:0] prev_colour;

  always #5 clk = ~clk;

  rle_video_prefetch #(
    .RUN_W      (RUN_W),
    .COLOUR_W   (COLOUR_W),
    .FIFO_DEPTH (4),
    .REPEAT     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read_next  (read_next),
    .stop_data  (stop_data),
    .data_ready (data_ready),
    .data       (data),
    .next_frame (next_frame),
    .next_pixel (next_pixel),
    .colour     (colour),
    .save_addr  (save_addr),
    .load_addr  (load_addr),
    .clear_addr (clear_addr),
    .fifo_count (fifo_count),
    .underrun   (underrun)
  );

  function automatic string kname(int k);
    case (k)
      EV_CLEAR: return "clear_addr";
      EV_COL:   return "colour";
      EV_SAVE:  return "save_addr(count)";
      EV_LOAD:  return "load_addr(stop,read)";
      EV_UNDR:  return "underrun(colour)";
      default:  return "pixel(colour)";
    endcase
  endfunction

  function automatic logic [DW-1:0] w(int r, int c);
    logic [DW-1:0] x;
    x = {r[RUN_W-1:0], c[COLOUR_W-1:0]};
    return x;
  endfunction

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(int k, int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(int k, int v);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected %s event: got 0x%0h, expected no event", kname(k), v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        n_fail++;
        $display("FAIL event order/value: got %s=0x%0h, expected %s=0x%0h",
                 kname(k), v, kname(e.kind), e.val);
      end
    end
  endtask

  task automatic cyc(logic nf, logic np);
    @(posedge clk);
    #1;
    next_frame = nf;
    next_pixel = np;
  endtask

  // Monitor: every observable output event pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (clear_addr !== prev_clear) observe(EV_CLEAR, int'(clear_addr));
        if (colour !== prev_colour)    observe(EV_COL, int'(colour));
        if (save_addr)                 observe(EV_SAVE, int'(fifo_count));
        if (load_addr)                 observe(EV_LOAD, int'({stop_data, read_next}));
        if (underrun)                  observe(EV_UNDR, int'(colour));
        if (next_pixel)                observe(EV_PIX, int'(colour));
        prev_clear  = clear_addr;
        prev_colour = colour;
      end
    end
  end

  // Stream reader model: offers queued words, retires one per transfer.
  initial begin
    forever begin
      @(negedge clk);
      xfer = read_next && data_ready;
      @(posedge clk);
      #2;
      if (xfer && feed_q.size() > 0) void'(feed_q.pop_front());
      data_ready = feed_en && (feed_q.size() > 0);
      data       = (feed_q.size() > 0) ? feed_q[0] : '0;
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected end of sequence");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset colour", int'(colour), 0);
    check("reset clear_addr", int'(clear_addr), 1);
    check("reset fifo_count", int'(fifo_count), 0);
    check("reset underrun", int'(underrun), 0);
    check("reset read_next", int'(read_next), 0);
    check("reset save_addr", int'(save_addr), 0);
    check("reset load_addr", int'(load_addr), 0);
    check("reset stop_data", int'(stop_data), 1);
    prev_clear  = 1'b1;
    prev_colour = '0;
    mon_en      = 1'b1;
    rst         = 1'b0;
    feed_en     = 1'b1;

    // Basic decode: runs of 3 and 2, back-to-back pixels.
    feed_q.push_back(w(3, 'h11));
    feed_q.push_back(w(2, 'h22));
    expect_ev(EV_SAVE, 0);
    expect_ev(EV_CLEAR, 0);
    expect_ev(EV_COL, 'h11);
    cyc(1, 0);
    repeat (3) cyc(0, 0);
    expect_ev(EV_PIX, 'h11);
    expect_ev(EV_PIX, 'h11);
    expect_ev(EV_PIX, 'h11);
    expect_ev(EV_COL, 'h22);
    expect_ev(EV_PIX, 'h22);
    repeat (4) cyc(0, 1);
    repeat (2) cyc(0, 0);

    // Starved run end: one underrun pulse, colour held.
    expect_ev(EV_PIX, 'h22);
    expect_ev(EV_UNDR, 'h22);
    cyc(0, 1);
    repeat (4) cyc(0, 0);
    check("underrun single pulse", int'(underrun), 0);
    check("colour held on underrun", int'(colour), 'h22);

    // Zero-run word shows its colour for one cycle without consuming a pixel.
    feed_q.push_back(w(0, 'h3F));
    feed_q.push_back(w(2, 'h01));
    feed_q.push_back(w(1, 'h2A));
    expect_ev(EV_COL, 'h3F);
    expect_ev(EV_COL, 'h01);
    repeat (4) cyc(0, 0);
    expect_ev(EV_PIX, 'h01);
    expect_ev(EV_PIX, 'h01);
    expect_ev(EV_COL, 'h2A);
    repeat (2) cyc(0, 1);
    repeat (2) cyc(0, 0);

    // Repeat frame: load flushes the FIFO, then a later save reports occupancy.
    feed_q.push_back(w(5, 'h05));
    feed_q.push_back(w(4, 'h06));
    feed_q.push_back(w(3, 'h07));
    repeat (4) cyc(0, 0);
    check("fifo_count before load", int'(fifo_count), 3);
    expect_ev(EV_LOAD, 2);
    cyc(1, 0);
    cyc(0, 0);
    check("fifo_count after load", int'(fifo_count), 0);
    check("read_next after load", int'(read_next), 1);
    feed_q.push_back(w(2, 'h05));
    feed_q.push_back(w(2, 'h09));
    feed_q.push_back(w(2, 'h0C));
    expect_ev(EV_COL, 'h05);
    repeat (4) cyc(0, 0);
    expect_ev(EV_SAVE, 2);
    expect_ev(EV_PIX, 'h05);
    cyc(1, 1);
    check("stop_data on save", int'(stop_data), 0);
    check("load_addr on save", int'(load_addr), 0);
    expect_ev(EV_PIX, 'h05);
    expect_ev(EV_PIX, 'h05);
    expect_ev(EV_COL, 'h09);
    repeat (2) cyc(0, 1);
    repeat (2) cyc(0, 0);

    // End marker returns to RESTART.
    feed_q.push_back(w(10'h3FF, 'h15));
    expect_ev(EV_PIX, 'h09);
    expect_ev(EV_PIX, 'h09);
    expect_ev(EV_COL, 'h0C);
    expect_ev(EV_PIX, 'h0C);
    expect_ev(EV_PIX, 'h0C);
    expect_ev(EV_CLEAR, 1);
    expect_ev(EV_COL, 0);
    repeat (4) cyc(0, 1);
    repeat (3) cyc(0, 0);
    check("restart colour", int'(colour), 0);
    check("restart clear_addr", int'(clear_addr), 1);
    check("restart stop_data", int'(stop_data), 1);
    check("restart read_next", int'(read_next), 0);

    // Resume, fill the FIFO, then reset mid-run.
    feed_q.push_back(w(1, 'h33));
    feed_q.push_back(w(4, 'h10));
    feed_q.push_back(w(4, 'h11));
    feed_q.push_back(w(4, 'h12));
    expect_ev(EV_SAVE, 0);
    expect_ev(EV_CLEAR, 0);
    expect_ev(EV_COL, 'h33);
    cyc(1, 0);
    repeat (6) cyc(0, 0);
    check("fifo_count before reset", int'(fifo_count), 3);
    check("colour before reset", int'(colour), 'h33);
    expect_ev(EV_CLEAR, 1);
    expect_ev(EV_COL, 0);
    rst = 1'b1;
    #1;
    check("async reset fifo_count", int'(fifo_count), 0);
    check("async reset colour", int'(colour), 0);
    check("async reset clear_addr", int'(clear_addr), 1);
    repeat (2) cyc(0, 0);
    rst = 1'b0;
    expect_ev(EV_SAVE, 0);
    expect_ev(EV_PIX, 0);
    expect_ev(EV_CLEAR, 0);
    cyc(1, 1);
    cyc(0, 0);
    feed_q.push_back(w(2, 'h2B));
    expect_ev(EV_COL, 'h2B);
    repeat (4) cyc(0, 0);

    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
